// File: rtl/alu_arbiter_if.sv
// Bundle of signals between alu_arbiter, its two requesters and the shared alu.
// slave is the arbiter's view; master is the view of the clients plus the alu.
interface alu_arbiter_if #(
  parameter int WIDTH = 8
);
  logic                 req0;
  logic                 req1;
  logic [WIDTH-1:0]     a0;
  logic [WIDTH-1:0]     b0;
  logic [WIDTH-1:0]     a1;
  logic [WIDTH-1:0]     b1;
  logic [3:0]           cmd0;
  logic [3:0]           cmd1;
  logic                 gnt0;
  logic                 gnt1;
  logic                 done0;
  logic                 done1;
  logic [2*WIDTH-1:0]   result;
  logic                 err;
  logic                 busy;
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [3:0]           alu_cmd;
  logic                 alu_oe;
  logic [2*WIDTH-1:0]   alu_dout;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cmd0, cmd1, alu_dout,
    output gnt0, gnt1, done0, done1, result, err, busy,
           alu_a, alu_b, alu_cmd, alu_oe
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, cmd0, cmd1, alu_dout,
    input  gnt0, gnt1, done0, done1, result, err, busy,
           alu_a, alu_b, alu_cmd, alu_oe
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational alu between two requesters.
// Each operation runs IDLE -> GRANT -> EXEC -> RESP, one op per four cycles at best.
module alu_arbiter #(
  parameter int         WIDTH   = 8,
  parameter logic [3:0] DIV_CMD = 4'b0101
) (
  input  logic          clock,
  input  logic          resetn,
  alu_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             state_q,  state_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [WIDTH-1:0]   b_q,      b_d;
  logic [3:0]         cmd_q,    cmd_d;
  logic               winner_q, winner_d;
  logic               prio_q,   prio_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               err_q,    err_d;

  logic               pick;
  logic               bypass;

  // prio_q names the requester that wins a tie.
  assign pick   = bus.req1 && (!bus.req0 || prio_q);
  assign bypass = (cmd_q == DIV_CMD) && (b_q == '0);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cmd_d    = cmd_q;
    winner_d = winner_q;
    prio_d   = prio_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          winner_d = pick;
          a_d      = pick ? bus.a1   : bus.a0;
          b_d      = pick ? bus.b1   : bus.b0;
          cmd_d    = pick ? bus.cmd1 : bus.cmd0;
          state_d  = GRANT;
        end
      end
      GRANT: begin
        state_d = EXEC;
      end
      EXEC: begin
        // Entering RESP: the other requester gets the next tie.
        prio_d  = ~winner_q;
        state_d = RESP;
        if (bypass) begin
          result_d = '0;
          err_d    = 1'b1;
        end else begin
          result_d = bus.alu_dout;
          err_d    = 1'b0;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cmd_q    <= '0;
      winner_q <= 1'b0;
      prio_q   <= 1'b0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cmd_q    <= cmd_d;
      winner_q <= winner_d;
      prio_q   <= prio_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.gnt0    = (state_q == GRANT) && !winner_q;
  assign bus.gnt1    = (state_q == GRANT) &&  winner_q;
  assign bus.done0   = (state_q == RESP)  && !winner_q;
  assign bus.done1   = (state_q == RESP)  &&  winner_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.result  = result_q;
  assign bus.err     = err_q;
  // The alu sees the latched operands for the whole operation; oe only in EXEC.
  assign bus.alu_a   = a_q;
  assign bus.alu_b   = b_q;
  assign bus.alu_cmd = cmd_q;
  assign bus.alu_oe  = (state_q == EXEC) && !bypass;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural alu and a
// transaction-level reference model of arbitration and results.
module tb_alu_arbiter;
  localparam int         W   = 8;
  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] MUL = 4'd2;
  localparam logic [3:0] DIV = 4'd5;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  alu_arbiter_if #(.WIDTH(W)) bus ();

  alu_arbiter #(.WIDTH(W), .DIV_CMD(4'b0101)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] c);
    case (c)
      4'd0:    return {8'd0, a} + {8'd0, b};
      4'd1:    return {8'd0, a} - {8'd0, b};
      4'd2:    return {8'd0, a} * {8'd0, b};
      4'd3:    return {8'd0, a & b};
      4'd4:    return {8'd0, a | b};
      4'd5:    return (b == 8'd0) ? 16'd0 : {8'd0, a / b};
      4'd6:    return {8'd0, a ^ b};
      4'd7:    return {8'd0, ~a};
      4'd8:    return {8'd0, a} << b[2:0];
      4'd9:    return {8'd0, a >> b[2:0]};
      4'd10:   return (b == 8'd0) ? 16'd0 : {8'd0, a % b};
      4'd11:   return {15'd0, a == b};
      4'd12:   return {15'd0, a < b};
      4'd13:   return {a, b};
      4'd14:   return {b, a};
      default: return {8'd0, a} + 16'd1;
    endcase
  endfunction

  // Expected (result, err) of one operation from the divide-by-zero rule.
  function automatic logic [16:0] expect_op(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] c);
    if (c == DIV && b == 8'd0) return {1'b1, 16'd0};
    return {1'b0, alu_ref(a, b, c)};
  endfunction

  assign bus.alu_dout = bus.alu_oe ? alu_ref(bus.alu_a, bus.alu_b, bus.alu_cmd) : 16'hDEAD;

  typedef struct {
    int          gnt_at;
    int          gnt_id;
    int          oe_cnt;
    int          oe_at;
    int          done_at;
    int          done_id;
    logic [15:0] res;
    logic        e;
    bit          timeout;
    bit          conflict;
  } obs_t;

  // Steps negedges, recording when grant/oe/done appear (cycle numbers relative to call).
  task automatic observe(input int limit, input bit drop, output obs_t o);
    o.gnt_at = -1; o.gnt_id = -1; o.oe_cnt = 0; o.oe_at = -1;
    o.done_at = -1; o.done_id = -1; o.res = '0; o.e = 1'b0;
    o.timeout = 1'b1; o.conflict = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clock);
      if ((bus.gnt0 && bus.gnt1) || (bus.done0 && bus.done1)) o.conflict = 1'b1;
      if ((bus.gnt0 || bus.gnt1) && o.gnt_at < 0) begin
        o.gnt_at = i;
        o.gnt_id = bus.gnt1 ? 1 : 0;
        if (drop) begin
          if (bus.gnt1) bus.req1 = 1'b0;
          else          bus.req0 = 1'b0;
        end
      end
      if (bus.alu_oe) begin
        o.oe_cnt++;
        o.oe_at = i;
      end
      if (bus.done0 || bus.done1) begin
        o.done_at = i;
        o.done_id = bus.done1 ? 1 : 0;
        o.res     = bus.result;
        o.e       = bus.err;
        o.timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic apply_reset();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    resetn   = 1'b0;
    repeat (2) @(negedge clock);
    resetn   = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    obs_t o;
    logic busy_seen, done_seen;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.result, bus.err, bus.busy,
         bus.alu_a, bus.alu_b, bus.alu_cmd, bus.alu_oe} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero, result=%h busy=%b alu_oe=%b",
               bus.result, bus.busy, bus.alu_oe);
    end
    resetn = 1'b1;
    @(negedge clock);
    bus.a0 = 8'd20; bus.b0 = 8'd10; bus.cmd0 = ADD; bus.req0 = 1'b1;
    observe(8, 1'b1, o);
    checks++;
    if (o.timeout || o.res !== 16'd30) begin
      errors++;
      $display("FAIL reset_preop_result: got %0d timeout=%0d expected 30", o.res, o.timeout);
    end
    @(negedge clock);
    bus.req0 = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_gnt0: got %b expected 1", bus.gnt0);
    end
    bus.req0 = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.alu_oe !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_exec_oe: got %b expected 1", bus.alu_oe);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.result, bus.err, bus.busy,
         bus.alu_a, bus.alu_b, bus.alu_cmd, bus.alu_oe} !== '0) begin
      errors++;
      $display("FAIL reset_async_clear: result=%h busy=%b alu_a=%h alu_oe=%b expected all 0",
               bus.result, bus.busy, bus.alu_a, bus.alu_oe);
    end
    @(negedge clock);
    resetn = 1'b1;
    busy_seen = 1'b0;
    done_seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      busy_seen = busy_seen | bus.busy;
      done_seen = done_seen | bus.done0 | bus.done1;
    end
    checks++;
    if (busy_seen !== 1'b0 || done_seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_abandon: busy_seen=%b done_seen=%b expected 0 0", busy_seen, done_seen);
    end
  endtask

  task automatic test_single();
    obs_t o;
    idle(2);
    bus.a0 = 8'd25; bus.b0 = 8'd17; bus.cmd0 = ADD; bus.req0 = 1'b1;
    observe(8, 1'b1, o);
    checks++;
    if (o.gnt_at != 1 || o.gnt_id != 0) begin
      errors++;
      $display("FAIL single_gnt: at=%0d id=%0d expected at=1 id=0", o.gnt_at, o.gnt_id);
    end
    checks++;
    if (o.oe_cnt != 1 || o.oe_at != 2) begin
      errors++;
      $display("FAIL single_oe: count=%0d at=%0d expected count=1 at=2", o.oe_cnt, o.oe_at);
    end
    checks++;
    if (o.done_at != 3 || o.done_id != 0) begin
      errors++;
      $display("FAIL single_done: at=%0d id=%0d expected at=3 id=0", o.done_at, o.done_id);
    end
    checks++;
    if (o.res !== 16'd42 || o.e !== 1'b0) begin
      errors++;
      $display("FAIL single_result: got %0d err=%b expected 42 err=0", o.res, o.e);
    end
  endtask

  task automatic test_simultaneous();
    obs_t o;
    int   exp_id;
    apply_reset();
    bus.a0 = 8'd3; bus.b0 = 8'd4; bus.cmd0 = MUL;
    bus.a1 = 8'd9; bus.b1 = 8'd2; bus.cmd1 = SUB;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = k % 2;
      observe(8, 1'b0, o);
      checks++;
      if (o.timeout || o.conflict || o.done_id != exp_id || o.gnt_id != exp_id) begin
        errors++;
        $display("FAIL simul_order[%0d]: gnt=%0d done=%0d conflict=%0d expected %0d",
                 k, o.gnt_id, o.done_id, o.conflict, exp_id);
      end
      checks++;
      if (o.res !== (exp_id == 1 ? 16'd7 : 16'd12) || o.done_at != (k == 0 ? 3 : 4)) begin
        errors++;
        $display("FAIL simul_result[%0d]: got %0d at %0d expected %0d at %0d",
                 k, o.res, o.done_at, (exp_id == 1 ? 7 : 12), (k == 0 ? 3 : 4));
      end
    end
    idle(2);
  endtask

  task automatic test_div_zero();
    obs_t o;
    idle(2);
    bus.a1 = 8'd8; bus.b1 = 8'd0; bus.cmd1 = DIV; bus.req1 = 1'b1;
    observe(8, 1'b1, o);
    checks++;
    if (o.timeout || o.oe_cnt != 0 || o.done_id != 1) begin
      errors++;
      $display("FAIL divzero_flow: oe_cnt=%0d done_id=%0d expected 0 1", o.oe_cnt, o.done_id);
    end
    checks++;
    if (o.res !== 16'd0 || o.e !== 1'b1) begin
      errors++;
      $display("FAIL divzero_result: got %0d err=%b expected 0 err=1", o.res, o.e);
    end
    bus.b1 = 8'd2; bus.req1 = 1'b1;
    observe(8, 1'b1, o);
    checks++;
    if (o.timeout || o.oe_cnt != 1 || o.res !== 16'd4 || o.e !== 1'b0) begin
      errors++;
      $display("FAIL div_ok: got %0d err=%b oe_cnt=%0d expected 4 err=0 oe_cnt=1",
               o.res, o.e, o.oe_cnt);
    end
  endtask

  task automatic test_busy_req();
    obs_t o;
    logic gnt1_seen;
    idle(2);
    bus.a0 = 8'd1; bus.b0 = 8'd2; bus.cmd0 = ADD; bus.req0 = 1'b1;
    bus.a1 = 8'd7; bus.b1 = 8'd5; bus.cmd1 = SUB;
    @(negedge clock);
    checks++;
    if (bus.gnt0 !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_grant: gnt0=%b busy=%b expected 1 1", bus.gnt0, bus.busy);
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.done0 !== 1'b1 || bus.result !== 16'd3) begin
      errors++;
      $display("FAIL busy_done0: done0=%b result=%0d expected 1 3", bus.done0, bus.result);
    end
    bus.req1 = 1'b0;
    gnt1_seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      gnt1_seen = gnt1_seen | bus.gnt1;
    end
    checks++;
    if (gnt1_seen !== 1'b0) begin
      errors++;
      $display("FAIL busy_dropped_req: gnt1 seen=%b expected 0", gnt1_seen);
    end
    bus.req0 = 1'b1;
    @(negedge clock);
    bus.req0 = 1'b0;
    bus.req1 = 1'b1;
    repeat (2) @(negedge clock);
    observe(8, 1'b1, o);
    checks++;
    if (o.timeout || o.gnt_id != 1 || o.gnt_at != 2 || o.res !== 16'd2) begin
      errors++;
      $display("FAIL busy_held_req: gnt_id=%0d gnt_at=%0d res=%0d expected 1 2 2",
               o.gnt_id, o.gnt_at, o.res);
    end
  endtask

  task automatic test_cmd_sweep();
    obs_t        o;
    int          total_oe;
    logic [16:0] exp;
    total_oe = 0;
    idle(2);
    for (int c = 0; c < 16; c++) begin
      bus.a0 = 8'd15; bus.b0 = 8'd3; bus.cmd0 = 4'(c); bus.req0 = 1'b1;
      exp = expect_op(8'd15, 8'd3, 4'(c));
      observe(8, 1'b1, o);
      total_oe += o.oe_cnt;
      checks++;
      if (o.timeout || o.res !== exp[15:0] || o.e !== exp[16]) begin
        errors++;
        $display("FAIL sweep_result[%0d]: got %h err=%b expected %h err=%b",
                 c, o.res, o.e, exp[15:0], exp[16]);
      end
      checks++;
      if (o.oe_cnt != 1 || o.done_at != (c == 0 ? 3 : 4)) begin
        errors++;
        $display("FAIL sweep_timing[%0d]: oe_cnt=%0d done_at=%0d expected 1 %0d",
                 c, o.oe_cnt, o.done_at, (c == 0 ? 3 : 4));
      end
    end
    checks++;
    if (total_oe != 16) begin
      errors++;
      $display("FAIL sweep_oe_total: got %0d expected 16", total_oe);
    end
    idle(2);
  endtask

  task automatic test_random();
    obs_t        o;
    int          pattern, exp_w, pref;
    logic [7:0]  ra [2];
    logic [7:0]  rb [2];
    logic [3:0]  rc [2];
    logic [16:0] exp;
    apply_reset();
    pref = 0;
    for (int it = 0; it < 40; it++) begin
      pattern = int'($urandom_range(1, 3));
      for (int r = 0; r < 2; r++) begin
        ra[r] = 8'($urandom);
        rb[r] = 8'($urandom);
        rc[r] = 4'($urandom);
        if ($urandom_range(0, 3) == 0) begin
          rc[r] = DIV;
          rb[r] = 8'd0;
        end
      end
      bus.a0 = ra[0]; bus.b0 = rb[0]; bus.cmd0 = rc[0];
      bus.a1 = ra[1]; bus.b1 = rb[1]; bus.cmd1 = rc[1];
      bus.req0 = (pattern & 1) != 0;
      bus.req1 = (pattern & 2) != 0;
      exp_w = (pattern == 3) ? pref : ((pattern == 2) ? 1 : 0);
      exp   = expect_op(ra[exp_w], rb[exp_w], rc[exp_w]);
      observe(8, 1'b1, o);
      idle(1);
      checks++;
      if (o.timeout || o.conflict || o.gnt_id != exp_w || o.done_id != exp_w) begin
        errors++;
        $display("FAIL rand_winner[%0d]: gnt=%0d done=%0d timeout=%0d expected %0d",
                 it, o.gnt_id, o.done_id, o.timeout, exp_w);
      end
      checks++;
      if (o.res !== exp[15:0] || o.e !== exp[16] || o.oe_cnt != (exp[16] ? 0 : 1)) begin
        errors++;
        $display("FAIL rand_result[%0d]: got %h err=%b oe=%0d expected %h err=%b",
                 it, o.res, o.e, o.oe_cnt, exp[15:0], exp[16]);
      end
      pref = 1 - exp_w;
    end
  endtask

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.cmd0 = '0; bus.cmd1 = '0;
    test_reset();
    test_single();
    test_simultaneous();
    test_div_zero();
    test_busy_req();
    test_cmd_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
